key_sequencer: RTL and testbench

Front-end controller for the two-digit up/down counter datapath. Takes the raw `plus`/`minus` push-buttons, synchronizes and debounces them, resolves simultaneous presses, and issues single-cycle up/down strobes to the counter, with optional hold-to-repeat. It reads the counter's current value back and suppresses strobes that would leave the 0..MAX_VAL range the BCD display can show.

---
 rtl/key_sequencer.sv | 174 +++++++++++++++++
 tb/tb_key_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/key_sequencer.sv
// rtl/key_sequencer.sv - plus/minus button synchronizer, debouncer and up/down strobe sequencer
// Hold-to-repeat is built only when KEY_SEQ_AUTO_REPEAT_EN is defined.
module key_sequencer #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_RATE     = 16,
  parameter int MAX_VAL         = 99,
  parameter int CNT_W           = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             plus,
  input  logic             minus,
  input  logic [CNT_W-1:0] count_in,
  output logic             up_o,
  output logic             dn_o,
  output logic             busy
);

  localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_VAL);

  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 2 || REPEAT_RATE < 2 || MAX_VAL >= (1 << CNT_W)) begin : g_bad_cfg
    $error("key_sequencer: invalid parameter set");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_FIRST,
    S_HOLD,
    S_REPEAT,
    S_WAIT_REL
  } state_t;

  // Bit 0 is the plus button, bit 1 the minus button throughout.
  logic [1:0]      sync1;
  logic [1:0]      sync2;
  logic [1:0]      db;
  logic [DB_W-1:0] db_cnt [2];

  state_t state_q, state_d;
  logic   dir_q, dir_d;
  logic   strobe;
  logic   up_d, dn_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {minus, plus};
      sync2 <= sync1;
    end
  end

  // A disagreeing level must persist until the counter reaches DB_LAST before it is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db        <= '0;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db[i]     <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

`ifdef KEY_SEQ_AUTO_REPEAT_EN
  localparam int TMR_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] TMR_DELAY = TMR_W'(REPEAT_DELAY - 1);
  localparam logic [TMR_W-1:0] TMR_RATE  = TMR_W'(REPEAT_RATE - 1);

  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             held_lvl;
  logic             other_lvl;

  assign held_lvl  = dir_q ? db[0] : db[1];
  assign other_lvl = dir_q ? db[1] : db[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr_q <= '0;
    end else begin
      tmr_q <= tmr_d;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    strobe  = 1'b0;
`ifdef KEY_SEQ_AUTO_REPEAT_EN
    tmr_d   = tmr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (db[0] && db[1]) begin
          state_d = S_WAIT_REL;
        end else if (db[0]) begin
          state_d = S_FIRST;
          dir_d   = 1'b1;
        end else if (db[1]) begin
          state_d = S_FIRST;
          dir_d   = 1'b0;
        end
      end
      S_FIRST: begin
        strobe = 1'b1;
`ifdef KEY_SEQ_AUTO_REPEAT_EN
        tmr_d   = TMR_DELAY;
        state_d = S_HOLD;
`else
        state_d = S_WAIT_REL;
`endif
      end
`ifdef KEY_SEQ_AUTO_REPEAT_EN
      S_HOLD, S_REPEAT: begin
        // Release wins over a coincident timer expiry; a second button cancels repeating.
        if (!held_lvl) begin
          state_d = S_IDLE;
        end else if (other_lvl) begin
          state_d = S_WAIT_REL;
        end else if (tmr_q == '0) begin
          strobe  = 1'b1;
          tmr_d   = TMR_RATE;
          state_d = S_REPEAT;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
`endif
      S_WAIT_REL: begin
        if (db == 2'b00) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Out-of-range strobes are dropped here; the sequencer itself never stalls on the limit.
  assign up_d = strobe &&  dir_q && (count_in < CNT_MAX);
  assign dn_d = strobe && !dir_q && (count_in != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      dir_q   <= 1'b0;
      up_o    <= 1'b0;
      dn_o    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      up_o    <= up_d;
      dn_o    <= dn_d;
      busy    <= (state_d != S_IDLE);
    end
  end

endmodule

// File: tb/tb_key_sequencer.sv
// tb/tb_key_sequencer.sv - self-checking bench for key_sequencer
// Expectations follow KEY_SEQ_AUTO_REPEAT_EN when it is defined for the build.
module tb_key_sequencer;

  localparam int D    = 4;
  localparam int RD   = 20;
  localparam int RR   = 5;
  localparam int MAXN = 2000;
`ifdef KEY_SEQ_AUTO_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       plus;
  logic       minus;
  logic [6:0] count_in;
  logic       up_o;
  logic       dn_o;
  logic       busy;

  int n_chk  = 0;
  int n_fail = 0;

  logic       sp [MAXN];
  logic       sm [MAXN];
  logic [6:0] sc [MAXN];
  logic       hu [MAXN];
  logic       hd [MAXN];
  logic       hb [MAXN];
  logic       eu [MAXN];
  logic       ed [MAXN];

  typedef struct {
    bit is_plus;
    int cnt;
    int exp_up;
    int exp_dn;
    int exp_first;
  } tap_t;

  tap_t taps [9];

  key_sequencer #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_RATE    (RR),
    .MAX_VAL        (99),
    .CNT_W          (7)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .plus    (plus),
    .minus   (minus),
    .count_in(count_in),
    .up_o    (up_o),
    .dn_o    (dn_o),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_stim();
    for (int i = 0; i < MAXN; i++) begin
      sp[i] = 1'b0; sm[i] = 1'b0; sc[i] = 7'd50;
      hu[i] = 1'b0; hd[i] = 1'b0; hb[i] = 1'b0;
      eu[i] = 1'b0; ed[i] = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; plus = 1'b0; minus = 1'b0; count_in = 7'd50;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Edge e samples sp/sm/sc[e]; outputs are captured 1 time unit after that edge.
  task automatic run(input int n);
    for (int e = 1; e <= n; e++) begin
      plus = sp[e]; minus = sm[e]; count_in = sc[e];
      @(posedge clk);
      #1;
      hu[e] = up_o; hd[e] = dn_o; hb[e] = busy;
    end
  endtask

  task automatic tally(input int n, output int ups, output int dns, output int first);
    ups = 0; dns = 0; first = 0;
    for (int e = 1; e <= n; e++) begin
      if (hu[e]) ups++;
      if (hd[e]) dns++;
      if ((hu[e] || hd[e]) && first == 0) first = e;
    end
  endtask

  // Behavioural expectation for a clean press starting at edge t lasting len edges.
  task automatic model_press(input int t, input int len, input bit up_dir, input int c);
    int f;
    int last;
    bit allow;
    f     = t + D + 4;
    last  = t + len + D + 2;
    allow = up_dir ? (c < 99) : (c != 0);
    if (allow) begin
      if (up_dir) eu[f] = 1'b1; else ed[f] = 1'b1;
      if (REP) begin
        for (int s = f + RD; s <= last; s += RR) begin
          if (up_dir) eu[s] = 1'b1; else ed[s] = 1'b1;
        end
      end
    end
  endtask

  initial begin
    int ups, dns, first, cur, len, gap, c, pick;
    bit dir;
    int picks [7];

    taps[0] = '{1'b1, 50,  1, 0, 9};
    taps[1] = '{1'b1, 99,  0, 0, 0};
    taps[2] = '{1'b0, 0,   0, 0, 0};
    taps[3] = '{1'b1, 0,   1, 0, 9};
    taps[4] = '{1'b0, 50,  0, 1, 9};
    taps[5] = '{1'b1, 100, 0, 0, 0};
    taps[6] = '{1'b0, 100, 0, 1, 9};
    taps[7] = '{1'b0, 1,   0, 1, 9};
    taps[8] = '{1'b1, 98,  1, 0, 9};
    picks   = '{0, 1, 50, 98, 99, 100, 127};

    do_reset();
    chk("reset up_o", int'(up_o), 0);
    chk("reset dn_o", int'(dn_o), 0);
    chk("reset busy", int'(busy), 0);

    for (int k = 0; k < 9; k++) begin
      clear_stim();
      do_reset();
      for (int e = 1; e <= 12; e++) begin
        if (taps[k].is_plus) sp[e] = 1'b1; else sm[e] = 1'b1;
      end
      for (int e = 1; e < 40; e++) sc[e] = 7'(taps[k].cnt);
      run(35);
      tally(35, ups, dns, first);
      chk($sformatf("tap%0d up count", k), ups, taps[k].exp_up);
      chk($sformatf("tap%0d dn count", k), dns, taps[k].exp_dn);
      chk($sformatf("tap%0d first edge", k), first, taps[k].exp_first);
    end

    // Hold plus for 60 edges.
    clear_stim();
    do_reset();
    for (int e = 1; e <= 60; e++) sp[e] = 1'b1;
    run(80);
    tally(80, ups, dns, first);
    chk("hold up count", ups, REP ? 9 : 1);
    chk("hold first", first, 9);
    chk("hold edge29 up", int'(hu[29]), int'(REP));
    chk("hold edge64 up", int'(hu[64]), int'(REP));
    chk("hold dn count", dns, 0);

    // Bounce: 2-on/2-off for 20 edges, then stable high from edge 21.
    clear_stim();
    do_reset();
    for (int e = 1; e <= 20; e++) sp[e] = (((e - 1) / 2) % 2) == 0;
    for (int e = 21; e <= 40; e++) sp[e] = 1'b1;
    run(55);
    tally(55, ups, dns, first);
    chk("bounce first", first, 29);
    chk("bounce up count", ups, 1);

    // Simultaneous press for 15 edges.
    clear_stim();
    do_reset();
    for (int e = 1; e <= 15; e++) begin sp[e] = 1'b1; sm[e] = 1'b1; end
    run(30);
    tally(30, ups, dns, first);
    chk("simul strobes", ups + dns, 0);
    chk("simul busy@6", int'(hb[6]), 0);
    chk("simul busy@10", int'(hb[10]), 1);
    chk("simul busy@22", int'(hb[22]), 1);
    chk("simul busy@24", int'(hb[24]), 0);

    // Reset while minus is held and repeating.
    clear_stim();
    do_reset();
    for (int e = 1; e <= 40; e++) sm[e] = 1'b1;
    run(40);
    chk("prereset busy", int'(hb[40]), 1);
    rst_n = 1'b0;
    #1;
    chk("rst dn_o now", int'(dn_o), 0);
    chk("rst busy now", int'(busy), 0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk("rst dn_o held", int'(dn_o), 0);
      chk("rst busy held", int'(busy), 0);
    end
    rst_n = 1'b1;
    clear_stim();
    for (int e = 1; e <= 30; e++) sm[e] = 1'b1;
    run(30);
    tally(30, ups, dns, first);
    chk("post-reset first dn", first, 9);
    chk("post-reset dn@9", int'(hd[9]), 1);

    // Randomized clean presses against the press-level model.
    clear_stim();
    do_reset();
    cur = 1;
    while (cur + 60 + 30 + 10 < MAXN - 20) begin
      dir = 1'($urandom_range(0, 1));
      len = int'($urandom_range(D + 1, 60));
      gap = int'($urandom_range(D + 8, 30));
      pick = int'($urandom_range(0, 7));
      c = (pick == 7) ? int'($urandom_range(0, 127)) : picks[pick];
      for (int e = cur; e < cur + len; e++) begin
        if (dir) sp[e] = 1'b1; else sm[e] = 1'b1;
      end
      for (int e = cur; e < cur + len + gap; e++) sc[e] = 7'(c);
      model_press(cur, len, dir, c);
      cur += len + gap;
    end
    run(cur);
    for (int e = 1; e <= cur; e++) begin
      chk($sformatf("rand up@%0d", e), int'(hu[e]), int'(eu[e]));
      chk($sformatf("rand dn@%0d", e), int'(hd[e]), int'(ed[e]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
